fft_out_reorder: RTL and testbench
==================================

// Module: fft_out_reorder
// PURPOSE
//  Sink end of the PE chain output stream: drives output_ready into the last PE, accepts FFT_DATA_BUS
//  samples in bit-reversed bin order and re-emits each frame in natural bin order.
//  Ping-pong (2-bank) buffer: one bank fills while the other drains, so back-to-back frames stream
//  without gaps. Sits between the final PE stage and the accelerator output port.
// PARAMETERS
//  MAX_LOG2N  10  log2 of largest supported frame; each bank holds 2**MAX_LOG2N FFT_DATA_SAMPLE entries
// PORTS
//  clk           in   1                 clock, single domain
//  rst_n         in   1                 asynchronous active-low reset
//  in            in   FFT_DATA_BUS      sample stream from last PE, bit-reversed order, valid-qualified
//  output_ready  out  1                 to last PE; high = PE may pop a sample this cycle
//  log2n         in   4                 frame size log2, range 2..MAX_LOG2N (values <2 clamp to 2)
//  out           out  FFT_DATA_BUS      natural-order output stream, registered
//  out_ready     in   1                 downstream accepts out when out.valid && out_ready
//  out_last      out  1                 high with the final sample (bin N-1) of each frame
// BEHAVIOUR
//  Reset: out=0, out_last=0, output_ready=1, both banks EMPTY, wcnt=0, rcnt=0, wbank=0, skid empty.
//  Reset mid-frame discards all buffered data; no partial frame is emitted.
//  Upstream protocol: PE output is 1 cycle behind its pop, so a sample may arrive the cycle after
//   output_ready falls. 1-entry skid register captures it; no in.valid sample is ever dropped.
//   output_ready = write bank FILLING && skid empty.
//  Write side: wcnt counts accepted samples 0..N-1 (N=2**log2n); sample k stored at
//   bitrev(k, log2n) in write bank. log2n latched into frame register when wcnt==0 and a sample
//   is accepted; changes mid-frame are ignored until next frame.
//  Accept while write bank unavailable -> skid; skid drains into the write bank with priority over
//   in (output_ready held low until drained).
//  Bank state per bank: EMPTY -> FILLING (selected as write bank) -> FULL (wcnt hit N-1) ->
//   DRAINING (selected as read bank) -> EMPTY (last sample handed off).
//  Swap: when write bank becomes FULL and read bank is EMPTY, banks swap next cycle; wcnt=0.
//   If read bank still DRAINING, write side stalls (output_ready=0) until it empties.
//   Read-bank-empties and write-bank-fills in same cycle: swap in that same cycle, no bubble.
//  Read side: rcnt 0..N-1 reads sequentially; out register advances when out_ready || !out.valid.
//   out holds value and valid while out.valid && !out_ready.
//  Latency: last sample of frame accepted at cycle t -> bin 0 on out at t+2 (read bank idle).
//  Throughput: 1 sample/cycle sustained in and out with out_ready held high.
//  out_last asserts with bin N-1 only; out.data is passed unscaled (scaling applied by PEs).
//  Storage: 2 x 2**MAX_LOG2N x $bits(FFT_DATA_SAMPLE), synchronous read, 1-cycle read latency.
// CONFIGURATION
//  FFT_REORDER_INDEX_EN defined: adds port out_index out [MAX_LOG2N-1:0] = natural bin number of
//   the sample on out (equals rcnt of that sample, 0 when !out.valid, reset 0), timed with out.
//  Not defined: port absent; all other behaviour identical.
// TESTING
//  T1 log2n=2, in X0,X2,X1,X3 on 4 consecutive cycles, out_ready=1 -> out X0,X1,X2,X3 from cycle t+2, out_last on X3.
//  T2 log2n=3, 8 frames back-to-back, out_ready=1 -> 64 outputs in natural order, no gap after first frame.
//  T3 log2n=3, out_ready=0 for 20 cycles during drain -> output_ready drops after 2nd frame fills; out held, 0 samples lost.
//  T4 deassert output_ready while in.valid arrives next cycle -> sample lands in skid, appears at correct bin.
//  T5 change log2n 2->3 mid-frame -> current frame finishes as N=4, next frame N=8.
//  T6 assert rst_n=0 mid-drain -> out=0, output_ready=1 next cycle; next full frame reorders correctly.
//  T7 FFT_REORDER_INDEX_EN, log2n=4 -> out_index 0..15 aligned with out.valid.

Source files
------------

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong reorder buffer at the PE chain sink; bit-reversed FFT_DATA_BUS in, natural order out.
// Optional build macro FFT_REORDER_INDEX_EN adds out_index (natural bin number of the sample on out).

typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
} fft_data_sample_t;

typedef struct packed {
    logic             valid;
    fft_data_sample_t data;
} fft_data_bus_t;

module fft_out_reorder #(
    parameter int MAX_LOG2N = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  fft_data_bus_t        in,
    output logic                 output_ready,
    input  logic [3:0]           log2n,
    output fft_data_bus_t        out,
    input  logic                 out_ready,
`ifdef FFT_REORDER_INDEX_EN
    output logic [MAX_LOG2N-1:0] out_index,
`endif
    output logic                 out_last
);

    localparam int DEPTH = 2 ** MAX_LOG2N;
    localparam logic [MAX_LOG2N-1:0] ONES = '1;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    bank_state_e          bank_st_q [2];
    bank_state_e          bank_st_d [2];
    logic                 wbank_q, wbank_d;
    logic [MAX_LOG2N-1:0] wcnt_q, wcnt_d;
    logic [MAX_LOG2N-1:0] rcnt_q, rcnt_d;
    logic [3:0]           wlog2n_q, wlog2n_d;
    logic [3:0]           rlog2n_q, rlog2n_d;
    logic                 skid_valid_q, skid_valid_d;
    fft_data_sample_t     skid_data_q, skid_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    fft_data_sample_t     mem [2*DEPTH];
    fft_data_sample_t     rd_data_q;

    logic                 rbank, wr_avail, wr_en, rd_en, wr_frame_end, rd_frame_end, swap;
    logic [3:0]           log2n_clamped, wr_log2n;
    logic [MAX_LOG2N-1:0] wr_rev, wr_slot;
    logic [MAX_LOG2N:0]   wr_addr, rd_addr;
    fft_data_sample_t     wr_data;

    always_comb begin
        log2n_clamped = log2n;
        if (log2n < 4'd2) begin
            log2n_clamped = 4'd2;
        end else if (log2n > 4'(MAX_LOG2N)) begin
            log2n_clamped = 4'(MAX_LOG2N);
        end
    end

    always_comb begin
        rbank        = ~wbank_q;
        wr_avail     = (bank_st_q[wbank_q] == BANK_EMPTY) || (bank_st_q[wbank_q] == BANK_FILLING);
        output_ready = wr_avail && !skid_valid_q;
        // A frame's size is taken from log2n at its first accepted sample.
        wr_log2n     = (wcnt_q == '0) ? log2n_clamped : wlog2n_q;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            wr_rev[i] = wcnt_q[MAX_LOG2N-1-i];
        end
        wr_slot      = wr_rev >> (4'(MAX_LOG2N) - wr_log2n);
        wr_addr      = {wbank_q, wr_slot};
        rd_addr      = {rbank, rcnt_q};

        bank_st_d    = bank_st_q;
        wbank_d      = wbank_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        wlog2n_d     = wlog2n_q;
        rlog2n_d     = rlog2n_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        wr_en        = 1'b0;
        wr_data      = skid_data_q;
        wr_frame_end = 1'b0;
        rd_en        = 1'b0;
        rd_frame_end = 1'b0;

        // The skid always empties before a fresh input sample is written.
        if (skid_valid_q && wr_avail) begin
            wr_en        = 1'b1;
            wr_data      = skid_data_q;
            skid_valid_d = in.valid;
            skid_data_d  = in.data;
        end else if (in.valid && wr_avail) begin
            wr_en   = 1'b1;
            wr_data = in.data;
        end else if (in.valid) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in.data;
        end

        if (wr_en) begin
            bank_st_d[wbank_q] = BANK_FILLING;
            if (wcnt_q == '0) begin
                wlog2n_d = log2n_clamped;
            end
            if (wcnt_q == ~(ONES << wr_log2n)) begin
                wr_frame_end       = 1'b1;
                wcnt_d             = '0;
                bank_st_d[wbank_q] = BANK_FULL;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end else if (bank_st_q[wbank_q] == BANK_EMPTY) begin
            bank_st_d[wbank_q] = BANK_FILLING;
        end

        if (out_ready || !out_valid_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if ((bank_st_q[rbank] == BANK_FULL) || (bank_st_q[rbank] == BANK_DRAINING)) begin
                rd_en            = 1'b1;
                out_valid_d      = 1'b1;
                bank_st_d[rbank] = BANK_DRAINING;
                if (rcnt_q == ~(ONES << rlog2n_q)) begin
                    rd_frame_end     = 1'b1;
                    out_last_d       = 1'b1;
                    rcnt_d           = '0;
                    bank_st_d[rbank] = BANK_EMPTY;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
        end

        // Same-cycle fill/empty swaps immediately so streaming frames see no bubble.
        swap = ((bank_st_q[wbank_q] == BANK_FULL) || wr_frame_end) &&
               ((bank_st_q[rbank] == BANK_EMPTY) || rd_frame_end);
        if (swap) begin
            wbank_d          = rbank;
            bank_st_d[rbank] = BANK_FILLING;
            rlog2n_d         = wlog2n_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st_q[0] <= BANK_EMPTY;
            bank_st_q[1] <= BANK_EMPTY;
            wbank_q      <= 1'b0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            wlog2n_q     <= 4'd2;
            rlog2n_q     <= 4'd2;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            bank_st_q    <= bank_st_d;
            wbank_q      <= wbank_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            wlog2n_q     <= wlog2n_d;
            rlog2n_q     <= rlog2n_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    // Read data register doubles as the out data register; it is masked while out is invalid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    always_comb begin
        out       = '0;
        out.valid = out_valid_q;
        if (out_valid_q) begin
            out.data = rd_data_q;
        end
    end

    assign out_last = out_last_q;

`ifdef FFT_REORDER_INDEX_EN
    logic [MAX_LOG2N-1:0] out_idx_q, out_idx_d;

    always_comb begin
        out_idx_d = out_idx_q;
        if (out_ready || !out_valid_q) begin
            out_idx_d = rd_en ? rcnt_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_q <= '0;
        end else begin
            out_idx_q <= out_idx_d;
        end
    end

    assign out_index = out_idx_q;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: PE-like source with 1-cycle pop latency, natural-order scoreboard.
// Define FFT_REORDER_INDEX_EN to also score out_index.

module tb_fft_out_reorder;

    localparam int MAX_LOG2N = 10;
    localparam int W         = 1 + MAX_LOG2N + 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [32:0] in_bus;
    logic        output_ready;
    logic [3:0]  log2n;
    logic [32:0] out_bus;
    logic        out_ready;
    logic        out_last;
`ifdef FFT_REORDER_INDEX_EN
    logic [MAX_LOG2N-1:0] out_index;
`endif

    fft_out_reorder #(.MAX_LOG2N(MAX_LOG2N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in           (in_bus),
        .output_ready (output_ready),
        .log2n        (log2n),
        .out          (out_bus),
        .out_ready    (out_ready),
`ifdef FFT_REORDER_INDEX_EN
        .out_index    (out_index),
`endif
        .out_last     (out_last)
    );

    logic [W-1:0] exp_q[$];
    logic [31:0]  src_data_q[$];
    logic [3:0]   src_l2n_q[$];

    int n_checks      = 0;
    int n_errors      = 0;
    int cyc           = 0;
    int n_out         = 0;
    int last_in_cyc   = -1;
    int first_out_cyc = -1;
    int last_out_cyc  = -1;
    bit gap_en        = 1'b0;
    bit ready_rand    = 1'b0;
    bit saw_ready_low = 1'b0;

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bitrev(input int k, input int n);
        int r = 0;
        for (int b = 0; b < n; b++) begin
            if ((k & (1 << b)) != 0) r |= 1 << (n - 1 - b);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] mk_exp(input bit last, input int idx, input logic [31:0] d);
`ifdef FFT_REORDER_INDEX_EN
        return {last, MAX_LOG2N'(idx), d};
`else
        return {last, {MAX_LOG2N{1'b0}}, d};
`endif
    endfunction

    // Queue one frame: source in bit-reversed order, expectations in natural order.
    // mid_l2 < 0 drives random log2n on non-first samples (must be ignored by the DUT).
    task automatic send_frame(input int l2, input int mid_l2);
        int eff;
        int n;
        logic [31:0] x [16];
        eff = (l2 < 2) ? 2 : l2;
        n   = 1 << eff;
        for (int i = 0; i < n; i++) x[i] = $urandom;
        for (int k = 0; k < n; k++) begin
            src_data_q.push_back(x[bitrev(k, eff)]);
            if (k == 0) src_l2n_q.push_back(4'(l2));
            else if (mid_l2 < 0) src_l2n_q.push_back(4'($urandom_range(0, 4)));
            else src_l2n_q.push_back(4'(mid_l2));
        end
        for (int i = 0; i < n; i++) exp_q.push_back(mk_exp(i == n - 1, i, x[i]));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src_data_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // driver: pop while output_ready is high, present the sample one cycle later
    initial begin : driver
        bit          pop;
        logic [31:0] d;
        logic [3:0]  l;
        in_bus = '0;
        log2n  = 4'd2;
        d      = '0;
        l      = 4'd2;
        forever begin
            @(negedge clk);
            if (rst_n && !output_ready) saw_ready_low = 1'b1;
            pop = rst_n && output_ready && (src_data_q.size() > 0) &&
                  (!gap_en || ($urandom_range(0, 3) != 0));
            if (pop) begin
                d = src_data_q.pop_front();
                l = src_l2n_q.pop_front();
            end
            @(posedge clk);
            #1;
            if (pop) begin
                in_bus      = {1'b1, d};
                log2n       = l;
                last_in_cyc = cyc;
            end else begin
                in_bus = '0;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // scoreboard monitor
    initial begin : monitor
        logic [W-1:0]         got;
        logic [W-1:0]         exp;
        logic [MAX_LOG2N-1:0] idx_v;
        forever begin
            @(negedge clk);
            if (rst_n && out_bus[32] && out_ready) begin
                idx_v = '0;
`ifdef FFT_REORDER_INDEX_EN
                idx_v = out_index;
`endif
                got = {out_last, idx_v, out_bus[31:0]};
                n_out++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'(out_bus[32]), 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_sample", 64'(got), 64'(exp));
                end
            end
        end
    end

    initial begin : main
        int n0;
        int n;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out", 64'(out_bus), 64'd0);
        check("reset_out_last", 64'(out_last), 64'd0);
        check("reset_output_ready", 64'(output_ready), 64'd1);
`ifdef FFT_REORDER_INDEX_EN
        check("reset_out_index", 64'(out_index), 64'd0);
`endif
        #2 rst_n = 1'b1;

        // T1: N=4, bin 0 two cycles after the last accepted sample
        send_frame(2, -1);
        wait_drain("t1_drain", 100);
        check("t1_latency", 64'(first_out_cyc), 64'(last_in_cyc + 2));

        // T2: 8 back-to-back N=8 frames, gapless output
        first_out_cyc = -1;
        n0 = n_out;
        for (int f = 0; f < 8; f++) send_frame(3, -1);
        wait_drain("t2_drain", 400);
        check("t2_count", 64'(n_out - n0), 64'd64);
        check("t2_gapless", 64'(last_out_cyc - first_out_cyc), 64'd63);

        // T3/T4: downstream stall during drain, write side stalls, skid catches in-flight sample
        saw_ready_low = 1'b0;
        n0 = n_out;
        for (int f = 0; f < 4; f++) send_frame(3, -1);
        repeat (12) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain("t3_drain", 400);
        check("t3_ready_drop", 64'(saw_ready_low), 64'd1);
        check("t3_count", 64'(n_out - n0), 64'd32);

        // T5: log2n 2->3 mid-frame, then clamp of log2n<2
        send_frame(2, 3);
        send_frame(3, 3);
        send_frame(1, 3);
        send_frame(0, 4);
        wait_drain("t5_drain", 400);

        // random gaps on both sides, mixed sizes
        gap_en     = 1'b1;
        ready_rand = 1'b1;
        for (int f = 0; f < 6; f++) send_frame($urandom_range(1, 4), -1);
        wait_drain("rand_drain", 2000);
        ready_rand = 1'b0;
        gap_en     = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        // T7: N=16 frames (index scored when enabled)
        send_frame(4, -1);
        send_frame(4, -1);
        wait_drain("t7_drain", 400);

        // T6: reset mid-drain, then a clean frame
        n0 = n_out;
        send_frame(4, -1);
        send_frame(4, -1);
        n = 0;
        while (n_out < n0 + 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_drain", 64'(n_out >= n0 + 3), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        src_data_q.delete();
        src_l2n_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("t6_reset_out", 64'(out_bus), 64'd0);
        check("t6_reset_output_ready", 64'(output_ready), 64'd1);
        check("t6_reset_out_last", 64'(out_last), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        n0 = n_out;
        send_frame(3, -1);
        wait_drain("t6_drain", 200);
        check("t6_count", 64'(n_out - n0), 64'd8);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
